// File: rtl/prog_loader_if.sv
// Byte-stream handshake between a byte source and the program loader.
interface prog_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/prog_loader.sv
// Loads a header + 12-bit word stream into the SAP2 mini RAM via prog/a/d,
// then releases prog and pulses cpu_clr so the program starts from address 0.
module prog_loader (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    prog_loader_if.slave  rx,
    output logic          prog,
    output logic [7:0]    a,
    output logic [11:0]   d,
    output logic          cpu_clr,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {
        S_IDLE, S_BASE, S_COUNT, S_HI, S_LO, S_FINISH, S_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  base_q, base_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [3:0]  hi_q, hi_d;
    logic [7:0]  a_q, a_d;
    logic [11:0] d_q, d_d;
    logic        prog_q, prog_d;
    logic        cpu_clr_q, cpu_clr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        xfer;
    logic [8:0]  rem_dec;

    assign rx.rx_ready = (state_q == S_BASE) || (state_q == S_COUNT) ||
                         (state_q == S_HI)   || (state_q == S_LO);
    assign xfer    = rx.rx_valid & rx.rx_ready;
    assign rem_dec = remaining_q - 9'd1;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        a_d         = a_q;
        d_d         = d_q;
        prog_d      = prog_q;
        err_d       = err_q;
        cpu_clr_d   = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_BASE;
                err_d   = 1'b0;
            end
            S_BASE: if (xfer) begin
                base_d  = rx.rx_data;
                state_d = S_COUNT;
            end
            S_COUNT: if (xfer) begin
                remaining_d = (rx.rx_data == 8'd0) ? 9'd256 : {1'b0, rx.rx_data};
                state_d     = S_HI;
            end
            S_HI: if (xfer) begin
                if (rx.rx_data[7:4] != 4'd0) begin
                    state_d = S_ERROR;
                end else begin
                    hi_d    = rx.rx_data[3:0];
                    state_d = S_LO;
                end
            end
            S_LO: if (xfer) begin
                // prog is still low only until the first word of this load lands
                a_d         = prog_q ? a_q + 8'd1 : base_q;
                d_d         = {hi_q, rx.rx_data};
                prog_d      = 1'b1;
                remaining_d = rem_dec;
                state_d     = (rem_dec == 9'd0) ? S_FINISH : S_HI;
            end
            S_FINISH: begin
                prog_d    = 1'b0;
                cpu_clr_d = 1'b1;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            S_ERROR: begin
                prog_d  = 1'b0;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            base_q      <= 8'd0;
            remaining_q <= 9'd0;
            hi_q        <= 4'd0;
            a_q         <= 8'd0;
            d_q         <= 12'd0;
            prog_q      <= 1'b0;
            cpu_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            a_q         <= a_d;
            d_q         <= d_d;
            prog_q      <= prog_d;
            cpu_clr_q   <= cpu_clr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign prog    = prog_q;
    assign a       = a_q;
    assign d       = d_q;
    assign cpu_clr = cpu_clr_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: drives byte streams and compares a RAM fed by
// prog/a/d against an expected image built from the stream format.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        clr, start;
    logic        prog, cpu_clr, busy, done, err;
    logic [7:0]  a;
    logic [11:0] d;

    always #5 clk = ~clk;

    prog_loader_if rx_if();

    prog_loader dut (
        .clk(clk), .clr(clr), .start(start), .rx(rx_if),
        .prog(prog), .a(a), .d(d), .cpu_clr(cpu_clr),
        .busy(busy), .done(done), .err(err)
    );

    int          n_tests = 0, n_fail = 0;
    int          acc_cnt = 0, done_cnt = 0, cclr_cnt = 0;
    logic [11:0] ram     [256];
    logic [11:0] exp_ram [256];
    logic [7:0]  stream_q [$];
    logic [11:0] words_q  [$];

    // RAM behaves like the SAP2 mini: writes d to a on every edge while prog is high
    always @(posedge clk) begin
        if (prog === 1'b1) ram[a] = d;
        if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) acc_cnt++;
        if (done === 1'b1) done_cnt++;
        if (cpu_clr === 1'b1) cclr_cnt++;
    end

    task automatic clear_rams();
        for (int i = 0; i < 256; i++) begin
            logic [11:0] f;
            f = 12'($urandom);
            ram[i] = f;
            exp_ram[i] = f;
        end
    endtask

    function automatic int ram_diff(output int first);
        int n = 0;
        first = 0;
        for (int i = 255; i >= 0; i--)
            if (ram[i] !== exp_ram[i]) begin n++; first = i; end
        return n;
    endfunction

    // Expected image: word i lands at (base + i) mod 256
    task automatic apply_model(input logic [7:0] base);
        for (int i = 0; i < words_q.size(); i++)
            exp_ram[(int'(base) + i) % 256] = words_q[i];
    endtask

    task automatic build_load(input logic [7:0] base, input int cnt, input bit by_index);
        stream_q.delete();
        words_q.delete();
        stream_q.push_back(base);
        stream_q.push_back(8'(cnt));
        for (int i = 0; i < cnt; i++) begin
            logic [11:0] w;
            w = by_index ? 12'(i) : 12'($urandom);
            words_q.push_back(w);
            stream_q.push_back({4'h0, w[11:8]});
            stream_q.push_back(w[7:0]);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic send_stream(input int stall, input bit pulses, input bit chk_end);
        int idx = 0, cyc = 0, n;
        bit v, idle_rdy = 1'b0;
        n = stream_q.size();
        while (idx < n && cyc < 20000) begin
            @(negedge clk);
            v = (stall == 0) || ($urandom_range(0, 99) >= stall);
            start = pulses && ($urandom_range(0, 7) == 0);
            rx_if.rx_valid = v;
            rx_if.rx_data  = v ? stream_q[idx] : 8'($urandom);
            if (busy !== 1'b1 && rx_if.rx_ready !== 1'b0) idle_rdy = 1'b1;
            if (v && rx_if.rx_ready === 1'b1) idx++;
            cyc++;
        end
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
        start = 1'b0;
        n_tests++;
        if (idx != n) begin n_fail++; $display("FAIL stream_accept: got %0d bytes taken, want %0d", idx, n); end
        n_tests++;
        if (idle_rdy) begin n_fail++; $display("FAIL ready_in_idle: rx_ready seen high while busy low"); end
        if (chk_end) begin
            n_tests++;
            if (rx_if.rx_ready !== 1'b0) begin
                n_fail++; $display("FAIL ready_after_last: got %b want 0", rx_if.rx_ready);
            end
        end
    endtask

    task automatic wait_done(input int d0, input string tag);
        int c = 0;
        while (done_cnt == d0 && c < 2000) begin @(negedge clk); c++; end
        n_tests++;
        if (done_cnt != d0 + 1) begin
            n_fail++; $display("FAIL %s_done: got %0d pulses want 1", tag, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b1;
        rx_if.rx_valid = 1'b1; rx_if.rx_data = 8'h10;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if ({prog, a, d, cpu_clr, busy, done, err} !== 25'd0) begin
            n_fail++; $display("FAIL reset_outputs: got prog=%b a=%h d=%h cc=%b busy=%b done=%b err=%b want all 0",
                prog, a, d, cpu_clr, busy, done, err);
        end
        n_tests++;
        if (rx_if.rx_ready !== 1'b0 || acc_cnt != 0) begin
            n_fail++; $display("FAIL reset_ready: got rdy=%b accepted=%0d want 0/0", rx_if.rx_ready, acc_cnt);
        end
        clr = 1'b0; start = 1'b0; rx_if.rx_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [7:0] bs [0:5];
        int d0, c0, nd, fa;
        bs[0] = 8'h10; bs[1] = 8'h02; bs[2] = 8'h0A; bs[3] = 8'hBC; bs[4] = 8'h01; bs[5] = 8'h23;
        clear_rams();
        exp_ram[8'h10] = 12'hABC;
        exp_ram[8'h11] = 12'h123;
        d0 = done_cnt; c0 = cclr_cnt;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0; rx_if.rx_valid = 1'b1; rx_if.rx_data = bs[i];
            if (i == 3) begin
                n_tests++;
                if (prog !== 1'b0) begin n_fail++; $display("FAIL basic_prog_early: got %b want 0", prog); end
            end
            if (i == 4) begin
                n_tests++;
                if ({prog, a, d} !== {1'b1, 8'h10, 12'hABC}) begin
                    n_fail++; $display("FAIL basic_word1: got prog=%b a=%h d=%h want 1/10/abc", prog, a, d);
                end
            end
        end
        @(negedge clk) rx_if.rx_valid = 1'b0;
        n_tests++;
        if ({prog, a, d, rx_if.rx_ready, busy} !== {1'b1, 8'h11, 12'h123, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL basic_word2: got prog=%b a=%h d=%h rdy=%b busy=%b want 1/11/123/0/1",
                prog, a, d, rx_if.rx_ready, busy);
        end
        @(negedge clk);
        n_tests++;
        if ({prog, done, cpu_clr, busy} !== 4'b0110) begin
            n_fail++; $display("FAIL basic_finish: got prog=%b done=%b cc=%b busy=%b want 0/1/1/0", prog, done, cpu_clr, busy);
        end
        @(negedge clk);
        n_tests++;
        if ({done, cpu_clr} !== 2'b00 || done_cnt - d0 != 1 || cclr_cnt - c0 != 1) begin
            n_fail++; $display("FAIL basic_pulses: got done=%b cc=%b counts %0d/%0d want 0/0 counts 1/1",
                done, cpu_clr, done_cnt - d0, cclr_cnt - c0);
        end
        nd = ram_diff(fa);
        n_tests++;
        if (nd != 0) begin n_fail++; $display("FAIL basic_ram: %0d bad, @%h got %h want %h", nd, fa, ram[fa], exp_ram[fa]); end
    endtask

    task automatic test_wrap_256();
        int d0, a0, nd, fa;
        clear_rams();
        build_load(8'hFE, 256, 1'b1);
        apply_model(8'hFE);
        d0 = done_cnt; a0 = acc_cnt;
        do_start();
        send_stream(0, 1'b0, 1'b1);
        wait_done(d0, "wrap");
        n_tests++;
        if (acc_cnt - a0 != 514) begin n_fail++; $display("FAIL wrap_bytes: got %0d want 514", acc_cnt - a0); end
        n_tests++;
        if ({a, d, prog} !== {8'hFD, 12'h0FF, 1'b0}) begin
            n_fail++; $display("FAIL wrap_last: got a=%h d=%h prog=%b want fd/0ff/0", a, d, prog);
        end
        nd = ram_diff(fa);
        n_tests++;
        if (nd != 0) begin n_fail++; $display("FAIL wrap_ram: %0d bad, @%h got %h want %h", nd, fa, ram[fa], exp_ram[fa]); end
    endtask

    task automatic test_format_error();
        int d0, c0, nd, fa;
        clear_rams();
        stream_q = '{8'h00, 8'h03, 8'h05, 8'h55, 8'h30};
        exp_ram[0] = 12'h555;
        d0 = done_cnt; c0 = cclr_cnt;
        do_start();
        send_stream(0, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++;
        if ({err, prog, busy} !== 3'b100) begin
            n_fail++; $display("FAIL err_flag: got err=%b prog=%b busy=%b want 1/0/0", err, prog, busy);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (err !== 1'b1 || done_cnt != d0 || cclr_cnt != c0) begin
            n_fail++; $display("FAIL err_sticky: got err=%b done=%0d cc=%0d want 1/0/0", err, done_cnt - d0, cclr_cnt - c0);
        end
        nd = ram_diff(fa);
        n_tests++;
        if (nd != 0) begin n_fail++; $display("FAIL err_ram: %0d bad, @%h got %h want %h", nd, fa, ram[fa], exp_ram[fa]); end
        do_start();
        n_tests++;
        if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL err_clear: got err=%b busy=%b want 0/1", err, busy); end
        pulse_clr();
    endtask

    task automatic test_clr_mid();
        int d0, c0, nd, fa;
        clear_rams();
        stream_q = '{8'h40, 8'h03, 8'h07, 8'h9E, 8'h02, 8'h11};
        stream_q = stream_q[0:3];
        exp_ram[8'h40] = 12'h79E;
        d0 = done_cnt; c0 = cclr_cnt;
        do_start();
        send_stream(0, 1'b0, 1'b0);
        n_tests++;
        if (prog !== 1'b1) begin n_fail++; $display("FAIL clr_mid_prog_before: got %b want 1", prog); end
        clr = 1'b1; rx_if.rx_valid = 1'b1; rx_if.rx_data = 8'h02;
        @(negedge clk);
        clr = 1'b0; rx_if.rx_valid = 1'b0;
        n_tests++;
        if ({prog, busy} !== 2'b00) begin n_fail++; $display("FAIL clr_mid_state: got prog=%b busy=%b want 0/0", prog, busy); end
        repeat (5) @(negedge clk);
        n_tests++;
        if (done_cnt != d0 || cclr_cnt != c0) begin
            n_fail++; $display("FAIL clr_mid_pulses: got done=%0d cc=%0d want 0/0", done_cnt - d0, cclr_cnt - c0);
        end
        nd = ram_diff(fa);
        n_tests++;
        if (nd != 0) begin n_fail++; $display("FAIL clr_mid_ram: %0d bad, @%h got %h want %h", nd, fa, ram[fa], exp_ram[fa]); end
    endtask

    task automatic test_stalls();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] base;
            int cnt, d0, a0, nd, fa;
            base = 8'($urandom);
            cnt  = $urandom_range(1, 40);
            build_load(base, cnt, 1'b0);
            for (int pass = 0; pass < 2; pass++) begin
                clear_rams();
                apply_model(base);
                d0 = done_cnt;
                do_start();
                send_stream(pass ? 40 : 0, pass == 1, 1'b1);
                wait_done(d0, pass ? "stall" : "nostall");
                nd = ram_diff(fa);
                n_tests++;
                if (nd != 0) begin
                    n_fail++; $display("FAIL stall_ram[%0d/%0d]: %0d bad, @%h got %h want %h", it, pass, nd, fa, ram[fa], exp_ram[fa]);
                end
            end
            n_tests++;
            if ({a, d} !== {8'(int'(base) + cnt - 1), words_q[cnt - 1]}) begin
                n_fail++; $display("FAIL stall_hold: got a=%h d=%h want %h/%h", a, d, 8'(int'(base) + cnt - 1), words_q[cnt - 1]);
            end
            a0 = acc_cnt;
            rx_if.rx_valid = 1'b1;
            repeat (4) @(negedge clk);
            rx_if.rx_valid = 1'b0;
            n_tests++;
            if (acc_cnt != a0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL idle_ignore: got accepted=%0d busy=%b want 0/0", acc_cnt - a0, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d0, nd, fa;
        clear_rams();
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] base;
            base = 8'($urandom);
            build_load(base, $urandom_range(1, 30), 1'b0);
            apply_model(base);
            do_start();
            send_stream(0, 1'b0, 1'b1);
            wait_done(d0 + k, "b2b");
        end
        nd = ram_diff(fa);
        n_tests++;
        if (nd != 0) begin n_fail++; $display("FAIL b2b_ram: %0d bad, @%h got %h want %h", nd, fa, ram[fa], exp_ram[fa]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap_256();
        test_format_error();
        test_clr_mid();
        test_stalls();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
